// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream drain.
package fifo_rd_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned CNT_W     = $clog2(BUF_DEPTH) + 1;

  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream, seen from the drain stage (master)
// and from its surroundings (slave).
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             fifo_cs;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output fifo_cs, fifo_rd_en, m_valid, m_data, m_last,
    input  fifo_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_cs, fifo_rd_en, m_valid, m_data, m_last,
    output fifo_data, fifo_empty, m_ready
  );

endinterface

// File: rtl/fifo_rd_buf.sv
// Circular output buffer: one push and one pop per clock, registered storage, head word out.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_rd_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops a synchronous FIFO and presents words on a valid/ready stream.
// Reads are only issued when buffer occupancy plus reads in flight leave room, so every
// landing word has a slot. Optional packet framing on m_last: define FIFO_RD_PKT_LAST_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned PKT_LEN   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  fifo_rd_stream_if.master       bus_io,
  output logic [31:0]            words_sent_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  if (RD_LAT < 1 || RD_LAT > 2 || BUF_DEPTH < RD_LAT + 1 ||
      (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || PKT_LEN < 1) begin : g_param_err
    $error("fifo_rd_stream: illegal parameter combination");
  end

  rd_state_e         state_q;
  logic [RD_LAT-1:0] infl_q;
  logic [RD_LAT-1:0] infl_d;
  logic [31:0]       words_sent_q;
  logic [CntW-1:0]   buf_cnt;
  logic [CntW-1:0]   infl_cnt;
  logic [CntW:0]     credit_used;
  logic [WIDTH-1:0]  head;
  logic              rd_en;
  logic              land;
  logic              pop;

  // Count reads still travelling through the FIFO read pipeline.
  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < int'(RD_LAT); i++) infl_cnt = infl_cnt + CntW'(infl_q[i]);
  end

  // Credit check uses registered counts only, keeping m_ready off the read path.
  assign credit_used = {1'b0, buf_cnt} + {1'b0, infl_cnt};
  assign rd_en = (state_q == RUN) && !bus_io.fifo_empty &&
                 (credit_used < (CntW + 1)'(BUF_DEPTH));
  assign land  = infl_q[RD_LAT-1];
  assign pop   = bus_io.m_valid && bus_io.m_ready;

  // Shift the issued-read marker along so it lines up with the FIFO data.
  always_comb begin
    infl_d    = '0;
    infl_d[0] = rd_en;
    for (int i = 1; i < int'(RD_LAT); i++) infl_d[i] = infl_q[i-1];
  end

  // Control FSM, in-flight pipe and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      infl_q       <= '0;
      words_sent_q <= '0;
    end else begin
      infl_q <= infl_d;
      if (pop) words_sent_q <= words_sent_q + 32'd1;
      unique case (state_q)
        IDLE:    if (enable_i) state_q <= RUN;
        RUN:     if (!enable_i) state_q <= STOP;
        STOP: begin
          if (enable_i)                          state_q <= RUN;
          else if (infl_cnt == '0 && buf_cnt == '0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_rd_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (land),
    .push_data_i (bus_io.fifo_data),
    .pop_i       (pop),
    .count_o     (buf_cnt),
    .head_o      (head)
  );

  assign bus_io.fifo_rd_en = rd_en;
  assign bus_io.fifo_cs    = rd_en;
  assign bus_io.m_valid    = (buf_cnt != '0);
  assign bus_io.m_data     = head;
  assign words_sent_o      = words_sent_q;
  assign busy_o            = (state_q != IDLE);

`ifdef FIFO_RD_PKT_LAST_EN
  localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [BeatW-1:0] beat_q;

  // Beat position within the current packet, advanced per transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else if (pop) begin
      if (beat_q == BeatW'(PKT_LEN - 1)) beat_q <= '0;
      else                               beat_q <= beat_q + 1'b1;
    end
  end

  assign bus_io.m_last = bus_io.m_valid && (beat_q == BeatW'(PKT_LEN - 1));
`else
  assign bus_io.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a RD_LAT=2 FIFO model and an in-order reference queue.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned PKT_LEN   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] words_sent;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

  fifo_rd_stream #(
    .WIDTH     (WIDTH),
    .RD_LAT    (RD_LAT),
    .BUF_DEPTH (BUF_DEPTH),
    .PKT_LEN   (PKT_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .bus_io       (bus),
    .words_sent_o (words_sent),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: rd_en sampled at edge k, data_out valid after edge k+1 (RD_LAT=2).
  logic [31:0] fifo_q[$];
  logic [31:0] ref_q[$];
  logic [31:0] pipe1 = '0;
  logic [31:0] pop_tmp;
  int          fifo_cnt = 0;
  int          rd_cnt = 0;

  initial bus.fifo_data = '0;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_cnt++;
      pop_tmp = (fifo_q.size() > 0) ? fifo_q.pop_front() : 32'hdead_beef;
      pipe1 <= pop_tmp;
    end
    bus.fifo_data <= pipe1;
    fifo_cnt      <= fifo_q.size();
  end

  assign bus.fifo_empty = (fifo_cnt == 0);

  // Stream monitor: order, stability under backpressure, framing, cs/rd_en tie.
  int          beat = 0;
  int          last_seen = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] exp_word;
  logic        exp_last;

  always @(negedge clk) begin
    if (rst) begin
      beat       = 0;
      prev_stall = 1'b0;
    end else begin
      check("cs_eq_rd_en", 64'(bus.fifo_cs), 64'(bus.fifo_rd_en));
      if (prev_stall) begin
        check("stall_valid", 64'(bus.m_valid), 64'd1);
        check("stall_data", 64'(bus.m_data), 64'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        exp_word = (ref_q.size() > 0) ? ref_q.pop_front() : 32'hxxxx_xxxx;
        check("order", 64'(bus.m_data), 64'(exp_word));
`ifdef FIFO_RD_PKT_LAST_EN
        exp_last = (beat == int'(PKT_LEN) - 1);
`else
        exp_last = 1'b0;
`endif
        check("m_last", 64'(bus.m_last), 64'(exp_last));
        if (bus.m_last) last_seen++;
        beat = (beat == int'(PKT_LEN) - 1) ? 0 : beat + 1;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic load(input logic [31:0] w);
    fifo_q.push_back(w);
    ref_q.push_back(w);
  endtask

  initial begin
    int          rd_base;
    int          ws_base;
    logic [31:0] w0;
    logic [31:0] w;

    rst         = 1'b1;
    enable      = 1'b0;
    bus.m_ready = 1'b0;

    // 1: reset, then enable low never reads
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cs", 64'(bus.fifo_cs), 64'd0);
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_valid", 64'(bus.m_valid), 64'd0);
    check("rst_data", 64'(bus.m_data), 64'd0);
    check("rst_last", 64'(bus.m_last), 64'd0);
    check("rst_words", 64'(words_sent), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    load(32'd1); load(32'd100); load(32'd10000);
    repeat (5) begin
      @(negedge clk);
      check("idle_no_rd", 64'(bus.fifo_rd_en), 64'd0);
    end

    // 2: three words, latency RD_LAT+1 edges after enable is sampled
    @(posedge clk); #1 enable = 1'b1; bus.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_e0_valid", 64'(bus.m_valid), 64'd0);
    check("run_busy", 64'(busy), 64'd1);
    @(negedge clk); check("lat_e1_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk); check("lat_e2_valid", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    check("lat_e3_valid", 64'(bus.m_valid), 64'd1);
    check("t2_word0", 64'(bus.m_data), 64'd1);
    @(negedge clk); check("t2_word1", 64'(bus.m_data), 64'd100);
    @(negedge clk); check("t2_word2", 64'(bus.m_data), 64'd10000);
    @(negedge clk);
    check("t2_drained", 64'(bus.m_valid), 64'd0);
    check("t2_words", 64'(words_sent), 64'd3);
    @(posedge clk); #1 enable = 1'b0; bus.m_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_idle", 64'(busy), 64'd0);

    // 3: 128 words, no ready: exactly BUF_DEPTH reads then hold
    @(posedge clk); #1;
    for (int i = 0; i < 128; i++) begin
      w = $urandom();
      if (i == 0) w0 = w;
      load(w);
    end
    rd_base = rd_cnt;
    @(posedge clk); #1 enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_reads", 64'(rd_cnt - rd_base), 64'(BUF_DEPTH));
    check("t3_rd_off", 64'(bus.fifo_rd_en), 64'd0);
    check("t3_valid", 64'(bus.m_valid), 64'd1);
    check("t3_head", 64'(bus.m_data), 64'(w0));

    // 4: random backpressure drains everything in order
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1 bus.m_ready = 1'($urandom_range(0, 1));
      if (words_sent == 32'd131) break;
    end
    check("t4_words", 64'(words_sent), 64'd131);
    check("t4_ref_empty", 64'(ref_q.size()), 64'd0);
    @(negedge clk);
    check("t4_final_valid", 64'(bus.m_valid), 64'd0);
    @(posedge clk); #1 enable = 1'b0; bus.m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_idle", 64'(busy), 64'd0);

    // 5: drop enable with two reads in flight
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) load(32'h5000 + 32'(i * 3));
    rd_base = rd_cnt;
    ws_base = int'(words_sent);
    @(posedge clk); #1 enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t5_rd_before_drop", 64'(bus.fifo_rd_en), 64'd1);
    enable = 1'b0;
    @(posedge clk);
    repeat (6) begin
      @(negedge clk);
      check("t5_no_rd", 64'(bus.fifo_rd_en), 64'd0);
    end
    check("t5_reads", 64'(rd_cnt - rd_base), 64'd4);
    check("t5_delivered", 64'(int'(words_sent) - ws_base), 64'd4);
    check("t5_idle", 64'(busy), 64'd0);

    // Reset with the FIFO, discarding leftovers
    @(posedge clk); #1 rst = 1'b1;
    fifo_q.delete();
    ref_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_words", 64'(words_sent), 64'd0);
    check("rst2_valid", 64'(bus.m_valid), 64'd0);

    // 6: packet framing over 8 words
    last_seen = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) load(32'ha0 + 32'(i));
    @(posedge clk); #1 enable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (words_sent == 32'd8) break;
    end
    check("t6_words", 64'(words_sent), 64'd8);
`ifdef FIFO_RD_PKT_LAST_EN
    check("t6_last_count", 64'(last_seen), 64'd2);
`else
    check("t6_last_count", 64'(last_seen), 64'd0);
`endif
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_idle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
